// File: rtl/onehot_dec_pkg.sv
// Shared widths, FIFO sizing and sequencer state type for the one-hot decoder.
// Build option ONEHOT_DEC_GAP_EN adds a mandatory 1-cycle dead time between strobes.
package onehot_dec_pkg;

  localparam int IDX_W      = 3;
  localparam int OUT_W      = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = 1;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } dec_state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    return OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_dec_if.sv
// Index/valid/ready handshake from the upstream priority encoder.
interface onehot_dec_if;

  logic [onehot_dec_pkg::IDX_W-1:0] in_idx;
  logic                             in_valid;
  logic                             in_ready;

  modport master (output in_idx, in_valid, input in_ready);
  modport slave  (input in_idx, in_valid, output in_ready);

endinterface

// File: rtl/onehot_dec_fifo.sv
// 2-entry index FIFO; flush and reset empty it, reset also clears storage.
module onehot_dec_fifo
  import onehot_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] din,
  input  logic             pop,
  output logic [IDX_W-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [FIFO_DEPTH-1:0][IDX_W-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W-1:0]                 rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/onehot_dec.sv
// Registered 3-to-8 one-hot decoder: queues encoder indices and replays each as a held strobe.
// Define ONEHOT_DEC_GAP_EN to insert one all-zero cycle between consecutive strobes.
module onehot_dec
  import onehot_dec_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  onehot_dec_if.slave       enc,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  dec_state_t        state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0]  cur, cur_n;
  logic [IDX_W-1:0]  head;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop, load, nonempty;

  // ready looks only at the registered count, so a pop this cycle does not free a slot early
  assign enc.in_ready = (fifo_count < FIFO_FULL) && !flush;
  assign push         = enc.in_valid && enc.in_ready;
  assign nonempty     = (fifo_count != '0);

  onehot_dec_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (enc.in_idx),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    load    = 1'b0;
    case (state)
      IDLE: load = nonempty;
      HOLD: begin
        if (cnt != '0)
          cnt_n = cnt - HOLD_W'(1);
        else begin
`ifdef ONEHOT_DEC_GAP_EN
          state_n = GAP;
`else
          // back-to-back reload keeps the strobe train free of zero cycles
          if (nonempty) load = 1'b1;
          else          state_n = IDLE;
`endif
        end
      end
`ifdef ONEHOT_DEC_GAP_EN
      GAP: begin
        if (nonempty) load = 1'b1;
        else          state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = HOLD;
      cnt_n   = hold_len;
      cur_n   = head;
    end
  end

  assign pop       = load;
  assign out       = (state == HOLD) ? onehot(cur) : '0;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE) || nonempty;

endmodule
